acc_message_scheduler: RTL and testbench

SHA-256 message schedule stage of the transaction accelerator. Sits directly downstream of `acc_control_unit`. It loads the 512-bit message block the control unit fetched from Data Memory on `ms_init`. It then produces one 32-bit schedule word W_t per `ms_enable` cycle, t = 0..63, for the compression stage. A rolling 16-word window computes W_16..W_63 on the fly.

---
 rtl/acc_message_scheduler.sv | 130 +++++++++++++
 tb/tb_acc_message_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_message_scheduler.sv
// Purpose: SHA-256 message schedule; loads a 512-bit block, emits W_0..W_63 from a rolling 16-word window.
// Latency: W_0 visible the cycle after ms_init; each ms_enable advances one word on the next cycle.
// Backpressure: none; ms_enable paces the schedule, and ms_init restarts it (ms_init wins over ms_enable).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ms_init            load ms_block (sampled only in this cycle) and restart at round 0
//   ms_enable          advance to the next schedule word; ignored while no word is valid
//   ms_block           512-bit message block, word 0 in [511:480]
//   ms_w_out           current W_t, forced to 0 while ms_w_valid is low
//   ms_w_valid         ms_w_out holds a valid word
//   ms_round           index t of ms_w_out
//   ms_done            one-cycle pulse after W_63 has been consumed
//
// Build option: define ACC_MS_BYTE_SWAP_EN to byte-reverse each 32-bit word at load
// (little-endian memory images). Schedule arithmetic is the same in both builds.
module acc_message_scheduler #(
   parameter int WORD_WIDTH  = 32,
   parameter int BLOCK_WIDTH = 512,
   parameter int ROUND_COUNT = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ms_init,
   input  logic                   ms_enable,
   input  logic [BLOCK_WIDTH-1:0] ms_block,
   output logic [WORD_WIDTH-1:0]  ms_w_out,
   output logic                   ms_w_valid,
   output logic [5:0]             ms_round,
   output logic                   ms_done
);

   localparam int         NUM_WORDS  = BLOCK_WIDTH / WORD_WIDTH;
   localparam logic [5:0] LAST_ROUND = 6'(ROUND_COUNT - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t                state, state_nxt;
   logic [5:0]            round, round_nxt;
   logic                  done, done_nxt;
   logic                  load, adv;
   logic [WORD_WIDTH-1:0] w [NUM_WORDS];
   logic [WORD_WIDTH-1:0] load_word [NUM_WORDS];
   logic [WORD_WIDTH-1:0] w_new;

   function automatic logic [WORD_WIDTH-1:0] rotr(input logic [WORD_WIDTH-1:0] x, input int n);
      return (x >> n) | (x << (WORD_WIDTH - n));
   endfunction

   function automatic logic [WORD_WIDTH-1:0] sig0(input logic [WORD_WIDTH-1:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [WORD_WIDTH-1:0] sig1(input logic [WORD_WIDTH-1:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Slice the block into words; optional byte reversal for little-endian images.
   always_comb begin
      for (int i = 0; i < NUM_WORDS; i++) begin
         logic [WORD_WIDTH-1:0] raw;
         raw = ms_block[BLOCK_WIDTH-1-WORD_WIDTH*i -: WORD_WIDTH];
`ifdef ACC_MS_BYTE_SWAP_EN
         load_word[i] = {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
`else
         load_word[i] = raw;
`endif
      end
   end

   // Window holds W_t..W_t+15, so W_t+16 only needs taps 0, 1, 9 and 14.
   assign w_new = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

   always_comb begin
      state_nxt = state;
      round_nxt = round;
      done_nxt  = 1'b0;
      load      = 1'b0;
      adv       = 1'b0;
      if (ms_init) begin
         load      = 1'b1;
         state_nxt = S_RUN;
         round_nxt = '0;
      end else if (ms_enable && state == S_RUN) begin
         if (round == LAST_ROUND) begin
            // Last word consumed; window contents are left stale.
            state_nxt = S_IDLE;
            round_nxt = '0;
            done_nxt  = 1'b1;
         end else begin
            adv       = 1'b1;
            round_nxt = round + 6'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         round <= '0;
         done  <= 1'b0;
         for (int i = 0; i < NUM_WORDS; i++) begin
            w[i] <= '0;
         end
      end else begin
         state <= state_nxt;
         round <= round_nxt;
         done  <= done_nxt;
         if (load) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
               w[i] <= load_word[i];
            end
         end else if (adv) begin
            for (int i = 0; i < NUM_WORDS - 1; i++) begin
               w[i] <= w[i+1];
            end
            w[NUM_WORDS-1] <= w_new;
         end
      end
   end

   assign ms_w_valid = (state == S_RUN);
   assign ms_w_out   = ms_w_valid ? w[0] : '0;
   assign ms_round   = round;
   assign ms_done    = done;

endmodule

// File: tb/tb_acc_message_scheduler.sv
// Purpose: directed self-checking bench for acc_message_scheduler (reset, "abc" block, gapped enables,
// init/enable priority, post-done behaviour, optional byte-swap build).
// Latency: inputs driven #1 after the rising edge, outputs sampled at that same point.
// Backpressure: not applicable; ms_enable is the only pacing input.
module tb_acc_message_scheduler;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ms_init;
   logic         ms_enable;
   logic [511:0] ms_block;
   logic [31:0]  ms_w_out;
   logic         ms_w_valid;
   logic [5:0]   ms_round;
   logic         ms_done;

   int           checks   = 0;
   int           failures = 0;
   logic [31:0]  exp_w [64];

   always #5 clk = ~clk;

   acc_message_scheduler dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ms_init    (ms_init),
      .ms_enable  (ms_enable),
      .ms_block   (ms_block),
      .ms_w_out   (ms_w_out),
      .ms_w_valid (ms_w_valid),
      .ms_round   (ms_round),
      .ms_done    (ms_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bswap(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   // Word as it must sit in memory so that the DUT loads value v.
   function automatic logic [31:0] mem_word(input logic [31:0] v);
`ifdef ACC_MS_BYTE_SWAP_EN
      return bswap(v);
`else
      return v;
`endif
   endfunction

   // Textbook SHA-256 schedule over the full 64-entry array.
   task automatic build_model(input logic [511:0] blk);
      logic [31:0] m;
      for (int i = 0; i < 16; i++) begin
         m = blk[511-32*i -: 32];
`ifdef ACC_MS_BYTE_SWAP_EN
         exp_w[i] = bswap(m);
`else
         exp_w[i] = m;
`endif
      end
      for (int t = 16; t < 64; t++) begin
         exp_w[t] = (rr(exp_w[t-2], 17) ^ rr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                  + exp_w[t-7]
                  + (rr(exp_w[t-15], 7) ^ rr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                  + exp_w[t-16];
      end
   endtask

   function automatic logic [511:0] abc_block();
      logic [511:0] b;
      b = '0;
      b[511:480] = mem_word(32'h61626380);
      b[31:0]    = mem_word(32'h00000018);
      return b;
   endfunction

   function automatic logic [511:0] rand_block();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; ms_init = 1'b0; ms_enable = 1'b0; ms_block = '0;
      #3;
      checks++;
      if (ms_w_out !== 32'h0 || ms_w_valid !== 1'b0 || ms_round !== 6'd0 || ms_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got w=%h v=%b r=%0d d=%b exp all 0", ms_w_out, ms_w_valid, ms_round, ms_done);
      end
      tick(); tick();
      rst_n = 1'b1;
      tick();
      ms_block = rand_block(); ms_init = 1'b1;
      tick();
      ms_init = 1'b0; ms_enable = 1'b1;
      repeat (5) tick();
      checks++;
      if (ms_round !== 6'd5 || ms_w_valid !== 1'b1) begin
         failures++;
         $display("FAIL pre_abort_round got r=%0d v=%b exp r=5 v=1", ms_round, ms_w_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (ms_w_out !== 32'h0 || ms_w_valid !== 1'b0 || ms_round !== 6'd0 || ms_done !== 1'b0) begin
         failures++;
         $display("FAIL async_abort got w=%h v=%b r=%0d d=%b exp all 0", ms_w_out, ms_w_valid, ms_round, ms_done);
      end
      ms_enable = 1'b0;
      tick();
      rst_n = 1'b1;
      ms_enable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (ms_w_valid !== 1'b0 || ms_done !== 1'b0 || ms_round !== 6'd0) begin
            failures++;
            $display("FAIL idle_enable got v=%b d=%b r=%0d exp v=0 d=0 r=0", ms_w_valid, ms_done, ms_round);
         end
      end
      ms_enable = 1'b0;
      tick();
   endtask

   task automatic test_abc_and_post_done();
      int dones;
      ms_block = abc_block();
      build_model(ms_block);
      ms_init = 1'b1;
      tick();
      ms_init = 1'b0; ms_enable = 1'b1;
      for (int k = 0; k < 64; k++) begin
         checks++;
         if (ms_w_valid !== 1'b1 || ms_round !== 6'(k) || ms_w_out !== exp_w[k] || ms_done !== 1'b0) begin
            failures++;
            $display("FAIL abc_word t=%0d got w=%h r=%0d v=%b d=%b exp w=%h", k, ms_w_out, ms_round,
                     ms_w_valid, ms_done, exp_w[k]);
         end
         if (k == 0 || k == 16) begin
            checks++;
            if (ms_w_out !== 32'h61626380) begin
               failures++;
               $display("FAIL abc_hand t=%0d got %h exp 61626380", k, ms_w_out);
            end
         end
         if (k == 17) begin
            checks++;
            if (ms_w_out !== 32'h000F0000) begin
               failures++;
               $display("FAIL abc_hand t=17 got %h exp 000f0000", ms_w_out);
            end
         end
         tick();
      end
      checks++;
      if (ms_done !== 1'b1 || ms_w_valid !== 1'b0 || ms_w_out !== 32'h0 || ms_round !== 6'd0) begin
         failures++;
         $display("FAIL abc_done got d=%b v=%b w=%h r=%0d exp d=1 v=0 w=0 r=0", ms_done, ms_w_valid,
                  ms_w_out, ms_round);
      end
      dones = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (ms_done === 1'b1) dones++;
         checks++;
         if (ms_w_valid !== 1'b0 || ms_w_out !== 32'h0) begin
            failures++;
            $display("FAIL post_done got v=%b w=%h exp v=0 w=0", ms_w_valid, ms_w_out);
         end
      end
      checks++;
      if (dones != 0) begin
         failures++;
         $display("FAIL post_done_pulses got %0d exp 0", dones);
      end
      ms_enable = 1'b0;
      tick();
   endtask

   task automatic test_gapped_enable();
      int  exp_r;
      bit  finished;
      bit  en;
      ms_block = rand_block();
      build_model(ms_block);
      ms_init = 1'b1;
      tick();
      ms_init = 1'b0;
      exp_r = 0;
      finished = 1'b0;
      for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
         checks++;
         if (ms_w_valid !== 1'b1 || ms_round !== 6'(exp_r) || ms_w_out !== exp_w[exp_r] || ms_done !== 1'b0) begin
            failures++;
            $display("FAIL gapped_word t=%0d got w=%h r=%0d v=%b exp w=%h", exp_r, ms_w_out, ms_round,
                     ms_w_valid, exp_w[exp_r]);
         end
         en = ($urandom_range(0, 9) < 3);
         ms_enable = en;
         ms_block  = rand_block();   // must not disturb the loaded block
         tick();
         if (en) begin
            if (exp_r == 63) finished = 1'b1;
            else exp_r++;
         end
      end
      checks++;
      if (!finished || ms_done !== 1'b1 || ms_w_valid !== 1'b0) begin
         failures++;
         $display("FAIL gapped_done got fin=%b d=%b v=%b exp fin=1 d=1 v=0", finished, ms_done, ms_w_valid);
      end
      ms_enable = 1'b0;
      tick();
   endtask

   task automatic test_init_priority();
      logic [511:0] blk_b;
      ms_block = rand_block();
      build_model(ms_block);
      ms_init = 1'b1;
      tick();
      ms_init = 1'b0; ms_enable = 1'b1;
      repeat (40) tick();
      checks++;
      if (ms_round !== 6'd40 || ms_w_out !== exp_w[40]) begin
         failures++;
         $display("FAIL prio_round40 got r=%0d w=%h exp r=40 w=%h", ms_round, ms_w_out, exp_w[40]);
      end
      blk_b = rand_block();
      build_model(blk_b);
      ms_block = blk_b; ms_init = 1'b1; ms_enable = 1'b1;
      tick();
      ms_init = 1'b0;
      checks++;
      if (ms_round !== 6'd0 || ms_w_out !== exp_w[0] || ms_w_valid !== 1'b1 || ms_done !== 1'b0) begin
         failures++;
         $display("FAIL prio_reload got r=%0d w=%h v=%b d=%b exp r=0 w=%h v=1 d=0", ms_round, ms_w_out,
                  ms_w_valid, ms_done, exp_w[0]);
      end
      tick();
      checks++;
      if (ms_round !== 6'd1 || ms_w_out !== exp_w[1]) begin
         failures++;
         $display("FAIL prio_next got r=%0d w=%h exp r=1 w=%h", ms_round, ms_w_out, exp_w[1]);
      end
      ms_enable = 1'b0;
      tick();
   endtask

`ifdef ACC_MS_BYTE_SWAP_EN
   task automatic test_byte_swap();
      logic [511:0] b;
      b = '0;
      b[511:480] = 32'h80636261;
      ms_block = b; ms_init = 1'b1;
      tick();
      ms_init = 1'b0;
      checks++;
      if (ms_w_out !== 32'h61626380 || ms_round !== 6'd0) begin
         failures++;
         $display("FAIL byte_swap got w=%h r=%0d exp w=61626380 r=0", ms_w_out, ms_round);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_abc_and_post_done();
      test_gapped_enable();
      test_init_priority();
`ifdef ACC_MS_BYTE_SWAP_EN
      test_byte_swap();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
